// File: rtl/sad_window_trigger.sv
// sad_window_trigger: sliding-window SAD trigger with exclude mask, holdoff, arm modes and trigger counter
module sad_window_trigger #(
  parameter int pREF_SAMPLES = 8,
  parameter int pBITS_PER_SAMPLE = 12,
  parameter int pHOLDOFF_W = 16,
  localparam int pLOG2N = $clog2(pREF_SAMPLES),
  localparam int pSAD_W = pBITS_PER_SAMPLE + pLOG2N,
  localparam int pLAT = 2 + pLOG2N
) (
  input  logic                        clk_adc,
  input  logic                        reset_n,
  input  logic [pBITS_PER_SAMPLE-1:0] adc_datain,
  input  logic                        active,
  input  logic                        armed_and_ready,
  input  logic                        always_armed,
  input  logic                        ref_wr,
  input  logic [pLOG2N-1:0]           ref_addr,
  input  logic [pBITS_PER_SAMPLE-1:0] ref_data,
  input  logic                        ref_excl,
  input  logic [pSAD_W-1:0]           threshold,
  input  logic [pHOLDOFF_W-1:0]       holdoff,
  input  logic                        count_clear,
  output logic                        trigger,
  output logic [pSAD_W-1:0]           sad_out,
  output logic                        sad_valid,
  output logic [15:0]                 trig_count
);
  localparam int N = pREF_SAMPLES;
  localparam int B = pBITS_PER_SAMPLE;
  localparam logic [pLOG2N:0] FULL = (pLOG2N+1)'(N);
  typedef enum logic [1:0] {IDLE, ARMED, HOLD, DONE} state_t;
  state_t                  r_state, w_nxt;
  logic [B-1:0]            r_win [N];
  logic [B-1:0]            r_ref [N];
  logic [N-1:0]            r_excl;
  logic [pLOG2N:0]         r_fill;
  logic [pLAT-2:0]         r_vld;
  logic [pSAD_W-1:0]       r_node [2*N-1];
  logic [B-1:0]            w_absd [N];
  logic [pHOLDOFF_W-1:0]   r_hcnt;
  logic                    r_trig;
  logic [15:0]             r_cnt;
  logic                    w_match, w_fire;

  always_comb
    for (int i = 0; i < N; i++)
      w_absd[i] = r_win[i] >= r_ref[i] ? r_win[i] - r_ref[i] : r_ref[i] - r_win[i];

  always_ff @(posedge clk_adc or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        r_win[i] <= '0;
        r_ref[i] <= '0;
      end
      r_excl <= '0;
      r_fill <= '0;
    end else begin
      for (int i = 0; i < N-1; i++) r_win[i] <= r_win[i+1];
      r_win[N-1] <= adc_datain;
      r_fill <= !active ? '0 : (r_fill == FULL) ? r_fill : r_fill + 1'b1;
      if (ref_wr && r_state == IDLE) begin
        r_ref[ref_addr] <= ref_data;
        r_excl[ref_addr] <= ref_excl;
      end
    end

  // heap-ordered adder tree: leaves at N-1..2N-2, node n sums 2n+1 and 2n+2, root lands pLOG2N stages later
  always_ff @(posedge clk_adc or negedge reset_n)
    if (!reset_n) begin
      for (int n = 0; n < 2*N-1; n++) r_node[n] <= '0;
      r_vld <= '0;
    end else begin
      for (int i = 0; i < N; i++) r_node[N-1+i] <= r_excl[i] ? '0 : pSAD_W'(w_absd[i]);
      for (int n = 0; n < N-1; n++) r_node[n] <= r_node[2*n+1] + r_node[2*n+2];
      r_vld <= active ? {r_vld[pLAT-3:0], r_fill == FULL} : '0;
    end

  assign sad_out = r_node[0];
  assign sad_valid = r_vld[pLAT-2];

  always_ff @(posedge clk_adc or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_nxt;

  always_comb begin
    w_match = sad_valid && (sad_out <= threshold);
    w_nxt = r_state;
    if (!active) w_nxt = IDLE;
    else
      case (r_state)
        IDLE:  w_nxt = (armed_and_ready || always_armed) ? ARMED : IDLE;
        ARMED: w_nxt = (!always_armed && !armed_and_ready) ? IDLE :
                       !w_match ? ARMED : !always_armed ? DONE : (holdoff == '0) ? ARMED : HOLD;
        HOLD:  w_nxt = (r_hcnt <= pHOLDOFF_W'(1)) ? ARMED : HOLD;
        DONE:  w_nxt = armed_and_ready ? DONE : IDLE;
      endcase
  end

  always_comb
    w_fire = active && r_state == ARMED && (always_armed || armed_and_ready) && w_match;

  always_ff @(posedge clk_adc or negedge reset_n)
    if (!reset_n) begin
      r_trig <= 1'b0;
      r_hcnt <= '0;
      r_cnt <= '0;
    end else begin
      r_trig <= w_fire;
      r_hcnt <= !active ? '0 : w_fire ? holdoff : (r_state == HOLD && r_hcnt != '0) ? r_hcnt - 1'b1 : r_hcnt;
      r_cnt <= count_clear ? '0 : (w_fire && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end

  assign trigger = r_trig;
  assign trig_count = r_cnt;
endmodule
